instr_fetch_unit: RTL and testbench

Fetches 32-bit instruction words from instruction memory and issues them, with their PC, to the main control decoder and register file over a valid/ready handshake. The decoder consumes `opcode` from this block. The block owns the program counter, sequences it by +4, and redirects it on taken branches from the datapath. It also discards any instruction-memory response that a redirect has made stale.

---
 rtl/instr_fetch_unit.sv | 101 ++++++++++
 tb/tb_instr_fetch_unit.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns the PC, requests words from imem, issues them with their PC to the decoder.
// Latency: ack in cycle N -> instr_valid in N+1; stalls in ISSUE while instr_ready is low.
module instr_fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic [5:0]        opcode
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        ISSUE = 2'd3
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] pc, pc_nxt, addr_nxt, instr_pc_nxt, target_pc;
    logic [31:0]       instr_nxt;

    assign target_pc   = redirect_pc & ~ADDR_W'(3);
    assign imem_req    = (state == FETCH) || (state == DRAIN);
    assign instr_valid = (state == ISSUE);
    assign opcode      = instr[31:26];

    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        addr_nxt     = imem_addr;
        instr_nxt    = instr;
        instr_pc_nxt = instr_pc;
        case (state)
            IDLE: begin
                state_nxt = FETCH;
                addr_nxt  = pc;
            end
            FETCH: begin
                if (redirect_valid && imem_ack) begin
                    pc_nxt   = target_pc;
                    addr_nxt = target_pc;
                end else if (redirect_valid) begin
                    pc_nxt    = target_pc;
                    state_nxt = DRAIN;
                end else if (imem_ack) begin
                    instr_nxt    = imem_rdata;
                    instr_pc_nxt = imem_addr;
                    pc_nxt       = pc + ADDR_W'(4);
                    state_nxt    = ISSUE;
                end
            end
            DRAIN: begin
                // the stale response is dropped; a coincident redirect wins the next fetch
                if (redirect_valid) pc_nxt = target_pc;
                if (imem_ack) begin
                    addr_nxt  = pc_nxt;
                    state_nxt = FETCH;
                end
            end
            ISSUE: begin
                if (redirect_valid) begin
                    pc_nxt    = target_pc;
                    addr_nxt  = target_pc;
                    state_nxt = FETCH;
                end else if (instr_ready) begin
                    addr_nxt  = pc;
                    state_nxt = FETCH;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            imem_addr <= RESET_PC;
            instr     <= '0;
            instr_pc  <= '0;
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            imem_addr <= addr_nxt;
            instr     <= instr_nxt;
            instr_pc  <= instr_pc_nxt;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus randomized memory latency, backpressure and redirects,
// checked against an issue-order model (next expected PC, memory contents as a function of address).
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req, imem_ack, instr_valid, instr_ready, redirect_valid;
    logic [31:0] imem_addr, imem_rdata, redirect_pc, instr, instr_pc;
    logic [5:0]  opcode;

    logic        w_req, w_ack, w_valid, w_ready, w_redir;
    logic [31:0] w_addr, w_rdata, w_rpc, w_instr, w_pc;
    logic [5:0]  w_opcode;

    int          n_assert = 0;
    int          n_fail = 0;
    int          hs_count = 0;
    int          idle_cyc = 0;
    int          wait_cnt = 0;
    int          lat = 0;
    int          cyc = 0;
    bit          sb_en = 1'b0;
    bit          spurious = 1'b0;
    logic [31:0] exp_pc = '0;
    logic [31:0] prev_addr = '0;
    logic        prev_req = 1'b0;
    logic        prev_ack = 1'b0;

    always #5 clk = ~clk;

    instr_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .instr_pc(instr_pc), .opcode(opcode)
    );

    // zero-wait memory, decoder always ready, starting just below the address wrap
    assign w_ack   = w_req;
    assign w_rdata = 32'hDEAD_BEEF;
    assign w_ready = 1'b1;
    assign w_redir = 1'b0;
    assign w_rpc   = '0;

    instr_fetch_unit #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .rst_n(rst_n),
        .imem_req(w_req), .imem_addr(w_addr), .imem_ack(w_ack), .imem_rdata(w_rdata),
        .redirect_valid(w_redir), .redirect_pc(w_rpc),
        .instr_valid(w_valid), .instr_ready(w_ready),
        .instr(w_instr), .instr_pc(w_pc), .opcode(w_opcode)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'd0) return 32'h8C01_0004;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // evaluated just before the rising edge, with this cycle's inputs and outputs settled
    task automatic scoreboard();
        logic [31:0] w;
        if (rst_n && sb_en) begin
            if (instr_valid && instr_ready) begin
                w = mem_word(exp_pc);
                chk("issue_pc", instr_pc, exp_pc);
                chk("issue_word", instr, w);
                chk("issue_opcode", {26'd0, opcode}, {26'd0, w[31:26]});
                exp_pc   = exp_pc + 32'd4;
                hs_count++;
                idle_cyc = 0;
            end else begin
                idle_cyc++;
                if (idle_cyc == 200) chk("progress_timeout", idle_cyc, 0);
            end
            if (redirect_valid) exp_pc = {redirect_pc[31:2], 2'b00};
            if (prev_req && !prev_ack && imem_req) chk("addr_stable", imem_addr, prev_addr);
            if (instr_valid) chk("no_req_in_issue", {31'd0, imem_req}, 32'd0);
        end
        prev_req  = imem_req & rst_n;
        prev_ack  = imem_ack;
        prev_addr = imem_addr;
    endtask

    // memory: acks after `lat` wait cycles; spurious acks while idle when enabled
    task automatic drive_mem();
        if (imem_req) begin
            if (wait_cnt == 0) begin
                imem_ack   = 1'b1;
                imem_rdata = mem_word(imem_addr);
                wait_cnt   = lat;
            end else begin
                imem_ack   = 1'b0;
                imem_rdata = $urandom;
                wait_cnt--;
            end
        end else begin
            wait_cnt   = lat;
            imem_ack   = spurious && ($urandom_range(0, 3) == 0);
            imem_rdata = $urandom;
        end
    endtask

    task automatic tick();
        #4;
        scoreboard();
        @(negedge clk);
        drive_mem();
        cyc++;
    endtask

    task automatic wait_valid();
        for (int k = 0; k < 20 && !instr_valid; k++) tick();
        chk("wait_valid", {31'd0, instr_valid}, 32'd1);
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        instr_ready    = 1'b0;
        imem_ack       = 1'b0;
        tick();
        tick();
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_addr", imem_addr, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_instr_pc", instr_pc, 32'd0);
        chk("rst_opcode", {26'd0, opcode}, 32'd0);
        exp_pc   = 32'd0;
        idle_cyc = 0;
        rst_n    = 1'b1;
        cyc      = 0;
    endtask

    initial begin
        logic [31:0] hold;
        logic [31:0] hold_op;
        int          hs0;
        int          hs_start;
        imem_ack       = 1'b0;
        imem_rdata     = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        instr_ready    = 1'b0;
        @(negedge clk);

        // reset release, sequential run with zero-wait memory, and the wrap instance alongside
        do_reset();
        instr_ready = 1'b1;
        lat         = 0;
        sb_en       = 1'b1;
        chk("idle_req", {31'd0, imem_req}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("seq_req", {31'd0, imem_req}, 32'd1);
            chk("seq_addr", imem_addr, 32'(4 * i));
            chk("seq_novalid", {31'd0, instr_valid}, 32'd0);
            if (i == 0) chk("wrap_first_addr", w_addr, 32'hFFFF_FFFC);
            if (i == 1) chk("wrap_second_addr", w_addr, 32'h0000_0000);
            tick();
            chk("seq_valid", {31'd0, instr_valid}, 32'd1);
            chk("seq_pc", instr_pc, 32'(4 * i));
            if (i == 0) begin
                chk("first_opcode", {26'd0, opcode}, 32'd35);
                chk("wrap_issue_pc", w_pc, 32'hFFFF_FFFC);
            end
        end

        // backpressure on the word at PC 12
        instr_ready = 1'b0;
        hold        = instr;
        hold_op     = {26'd0, opcode};
        hs0         = hs_count;
        repeat (5) begin
            tick();
            chk("bp_valid", {31'd0, instr_valid}, 32'd1);
            chk("bp_req", {31'd0, imem_req}, 32'd0);
            chk("bp_instr", instr, hold);
            chk("bp_pc", instr_pc, 32'd12);
            chk("bp_opcode", {26'd0, opcode}, hold_op);
        end
        instr_ready = 1'b1;
        tick();
        chk("bp_one_hs", 32'(hs_count - hs0), 32'd1);
        chk("bp_next_req", {31'd0, imem_req}, 32'd1);
        chk("bp_next_addr", imem_addr, 32'd16);

        // redirect to 0x40 in the first cycle of a 3-cycle fetch of address 8
        do_reset();
        instr_ready = 1'b1;
        lat         = 0;
        tick();
        tick();
        tick();
        lat = 2;
        tick();
        tick();
        chk("dr_addr8", imem_addr, 32'd8);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        tick();
        redirect_valid = 1'b0;
        chk("dr_hold_req", {31'd0, imem_req}, 32'd1);
        chk("dr_hold_addr", imem_addr, 32'd8);
        tick();
        chk("dr_hold_addr2", imem_addr, 32'd8);
        lat = 0;
        tick();
        chk("dr_new_req", {31'd0, imem_req}, 32'd1);
        chk("dr_new_addr", imem_addr, 32'h40);
        chk("dr_no_stale", {31'd0, instr_valid}, 32'd0);
        wait_valid();
        chk("dr_issue_pc", instr_pc, 32'h40);

        // redirect to 0x103 in ISSUE, without and then with the handshake
        instr_ready    = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h103;
        hs0            = hs_count;
        tick();
        redirect_valid = 1'b0;
        chk("sq_no_hs", 32'(hs_count - hs0), 32'd0);
        chk("sq_addr", imem_addr, 32'h100);
        wait_valid();
        chk("sq_issue_pc", instr_pc, 32'h100);
        instr_ready    = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h103;
        hs0            = hs_count;
        tick();
        redirect_valid = 1'b0;
        chk("rd_hs_once", 32'(hs_count - hs0), 32'd1);
        chk("rd_addr", imem_addr, 32'h100);
        lat = 3;
        wait_valid();
        chk("rd_issue_pc", instr_pc, 32'h100);

        // reset asserted while draining
        tick();
        chk("rd_fetch_req", {31'd0, imem_req}, 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        tick();
        redirect_valid = 1'b0;
        chk("drain_req", {31'd0, imem_req}, 32'd1);
        chk("drain_addr", imem_addr, 32'h104);
        rst_n = 1'b0;
        #1;
        chk("async_req", {31'd0, imem_req}, 32'd0);
        chk("async_valid", {31'd0, instr_valid}, 32'd0);
        chk("async_addr", imem_addr, 32'd0);
        chk("async_instr", instr, 32'd0);
        chk("async_pc", instr_pc, 32'd0);
        chk("async_opcode", {26'd0, opcode}, 32'd0);
        @(negedge clk);
        do_reset();
        lat = 0;
        tick();
        chk("restart_req", {31'd0, imem_req}, 32'd1);
        chk("restart_addr", imem_addr, 32'd0);

        // randomized latency, backpressure, redirects and spurious acks
        spurious = 1'b1;
        hs_start = hs_count;
        repeat (3000) begin
            instr_ready    = ($urandom_range(0, 3) != 0);
            lat            = $urandom_range(0, 3);
            redirect_valid = (cyc > 2) && ($urandom_range(0, 15) == 0);
            redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                          : $urandom;
            tick();
        end
        redirect_valid = 1'b0;
        chk("random_progress", {31'd0, (hs_count - hs_start) > 100}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
